// File: rtl/led_if_pkg.sv
// Shared types and defaults for the LED shift-interface receiver.
// Frame FSM states and the default frame width / synchronizer depth.
package led_if_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      CHECK = 2'd2
   } led_state_e;

   localparam int LED_WIDTH       = 16;
   localparam int LED_SYNC_STAGES = 2;

endpackage

// File: rtl/led_s2p_rx_sync_edge.sv
// Multi-flop synchronizer for one asynchronous pin, with a history flop
// so that rise/fall pulses line up with the synchronized level.
module sync_edge #(
   parameter int STAGES = 2
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_d,
   output logic o_level,
   output logic o_rise,
   output logic o_fall
);

   logic [STAGES-1:0] r_sync;
   logic              r_hist;

   // Synchronizer chain followed by one history flop for edge detection.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync <= '0;
         r_hist <= 1'b0;
      end else begin
         r_sync <= {r_sync[STAGES-2:0], i_d};
         r_hist <= r_sync[STAGES-1];
      end
   end

   assign o_level = r_sync[STAGES-1];
   assign o_rise  = r_sync[STAGES-1] & ~r_hist;
   assign o_fall  = ~r_sync[STAGES-1] & r_hist;

endmodule

// File: rtl/led_s2p_rx.sv
// Serial-to-parallel receiver for the LED shift interface: synchronizes the
// four pins into clk, frames each WIDTH-bit word and flags framing errors.
module led_s2p_rx
   import led_if_pkg::*;
#(
   parameter int WIDTH       = LED_WIDTH,
   parameter int SYNC_STAGES = LED_SYNC_STAGES
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       s_clk,
   input  logic                       s_do,
   input  logic                       s_en,
   input  logic                       s_clr_n,
   output logic [WIDTH-1:0]           dout,
   output logic                       dout_valid,
   output logic                       frame_err,
   output logic                       busy,
   output logic [$clog2(WIDTH+1)-1:0] bit_cnt
);

   localparam int CNT_W = $clog2(WIDTH+1);

   logic w_clk_lvl, w_clk_rise, w_clk_fall;
   logic w_en_lvl,  w_en_rise,  w_en_fall;
   logic w_clr_lvl, w_clr_rise, w_clr_fall;
   logic w_unused;

   logic [SYNC_STAGES-1:0] r_do_sync;
   logic                   w_do_sync;
   led_state_e             r_state;
   logic [WIDTH-1:0]       r_shreg;
   logic [CNT_W-1:0]       r_bit_cnt;
   logic [WIDTH-1:0]       r_dout;
   logic                   r_dout_valid;
   logic                   r_frame_err;

   sync_edge #(.STAGES(SYNC_STAGES)) u_sync_clk (
      .i_clk(clk), .i_rst_n(rst), .i_d(s_clk),
      .o_level(w_clk_lvl), .o_rise(w_clk_rise), .o_fall(w_clk_fall)
   );

   sync_edge #(.STAGES(SYNC_STAGES)) u_sync_en (
      .i_clk(clk), .i_rst_n(rst), .i_d(s_en),
      .o_level(w_en_lvl), .o_rise(w_en_rise), .o_fall(w_en_fall)
   );

   sync_edge #(.STAGES(SYNC_STAGES)) u_sync_clr (
      .i_clk(clk), .i_rst_n(rst), .i_d(s_clr_n),
      .o_level(w_clr_lvl), .o_rise(w_clr_rise), .o_fall(w_clr_fall)
   );

   assign w_unused = ^{w_clk_lvl, w_clk_fall, w_en_lvl, w_clr_rise, w_clr_fall};

   // Data has no history flop: its last stage lines up with the s_clk rise pulse.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_do_sync <= '0;
      end else begin
         r_do_sync <= {r_do_sync[SYNC_STAGES-2:0], s_do};
      end
   end

   assign w_do_sync = r_do_sync[SYNC_STAGES-1];

   // Frame FSM; a synchronized clear overrides every edge in the same cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= IDLE;
         r_shreg      <= '0;
         r_bit_cnt    <= '0;
         r_dout       <= '0;
         r_dout_valid <= 1'b0;
         r_frame_err  <= 1'b0;
      end else begin
         r_dout_valid <= 1'b0;
         r_frame_err  <= 1'b0;
         if (!w_clr_lvl) begin
            r_state   <= IDLE;
            r_shreg   <= '0;
            r_bit_cnt <= '0;
         end else begin
            case (r_state)
               IDLE: begin
                  if (w_en_rise) begin
                     r_state   <= SHIFT;
                     r_shreg   <= '0;
                     r_bit_cnt <= '0;
                  end else begin
                     r_state <= IDLE;
                  end
               end
               SHIFT: begin
                  // Count saturates one past WIDTH so overlong frames stay detectable.
                  if (w_clk_rise) begin
                     r_shreg <= {r_shreg[WIDTH-2:0], w_do_sync};
                     if (r_bit_cnt != CNT_W'(WIDTH + 1)) begin
                        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                     end else begin
                        r_bit_cnt <= r_bit_cnt;
                     end
                  end else begin
                     r_shreg <= r_shreg;
                  end
                  if (w_en_fall) begin
                     r_state <= CHECK;
                  end else begin
                     r_state <= SHIFT;
                  end
               end
               CHECK: begin
                  if (r_bit_cnt == CNT_W'(WIDTH)) begin
                     r_dout       <= r_shreg;
                     r_dout_valid <= 1'b1;
                  end else begin
                     r_frame_err  <= 1'b1;
                  end
                  r_state <= IDLE;
               end
               default: begin
                  r_state <= IDLE;
               end
            endcase
         end
      end
   end

   assign dout       = r_dout;
   assign dout_valid = r_dout_valid;
   assign frame_err  = r_frame_err;
   assign busy       = (r_state == SHIFT);
   assign bit_cnt    = r_bit_cnt;

endmodule

// File: tb/tb_led_s2p_rx.sv
// Directed and randomized frames against a word-level model of the receiver.
module tb_led_s2p_rx;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        s_clk = 1'b0;
   logic        s_do = 1'b0;
   logic        s_en = 1'b0;
   logic        s_clr_n = 1'b1;
   logic [15:0] dout;
   logic        dout_valid;
   logic        frame_err;
   logic        busy;
   logic [4:0]  bit_cnt;

   int          checks = 0;
   int          failures = 0;
   int          n_valid = 0;
   int          n_err = 0;
   int          n_both = 0;
   logic [15:0] exp_dout = 16'h0000;

   led_s2p_rx #(.WIDTH(16), .SYNC_STAGES(2)) dut (
      .clk(clk), .rst(rst), .s_clk(s_clk), .s_do(s_do), .s_en(s_en),
      .s_clr_n(s_clr_n), .dout(dout), .dout_valid(dout_valid),
      .frame_err(frame_err), .busy(busy), .bit_cnt(bit_cnt)
   );

   always #5 clk = ~clk;

   // Pulse monitor sampled on the falling edge.
   always @(negedge clk) begin
      if (dout_valid === 1'b1) n_valid++;
      if (frame_err === 1'b1) n_err++;
      if (dout_valid === 1'b1 && frame_err === 1'b1) n_both++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic start_frame();
      s_en = 1'b1;
      step(4);
   endtask

   // Sends the low n bits of w, MSB first, s_clk period 8 clk.
   task automatic shift_bits(input logic [31:0] w, input int n);
      for (int i = n - 1; i >= 0; i--) begin
         s_do = w[i];
         step(4);
         s_clk = 1'b1;
         step(4);
         s_clk = 1'b0;
      end
      step(2);
   endtask

   task automatic end_frame(input logic [31:0] w, input int n);
      int   v0;
      int   e0;
      logic ok;
      ok = (n == 16);
      chk("bit_cnt_pre", {27'd0, bit_cnt}, (n > 17) ? 32'd17 : 32'(n));
      chk("busy_in_frame", {31'd0, busy}, 32'd1);
      v0 = n_valid;
      e0 = n_err;
      s_en = 1'b0;
      step(3);
      chk("no_early_pulse", {31'd0, dout_valid | frame_err}, 32'd0);
      step(1);
      chk("valid_latency", {31'd0, dout_valid}, {31'd0, ok});
      chk("err_latency", {31'd0, frame_err}, {31'd0, ~ok});
      if (ok) exp_dout = w[15:0];
      step(3);
      chk("dout", {16'd0, dout}, {16'd0, exp_dout});
      chk("valid_count", 32'(n_valid - v0), {31'd0, ok});
      chk("err_count", 32'(n_err - e0), {31'd0, ~ok});
      chk("busy_after", {31'd0, busy}, 32'd0);
   endtask

   initial begin
      int v0;
      int e0;
      logic [31:0] rw;
      int rn;

      // Reset state
      step(2);
      chk("rst_dout", {16'd0, dout}, 32'd0);
      chk("rst_flags", {28'd0, dout_valid, frame_err, busy, 1'b0}, 32'd0);
      chk("rst_bit_cnt", {27'd0, bit_cnt}, 32'd0);
      rst = 1'b1;
      step(5);

      // Nominal frame
      start_frame();
      shift_bits(32'h0000A5C3, 16);
      end_frame(32'h0000A5C3, 16);

      // Short frame
      start_frame();
      shift_bits(32'h00007FFF, 15);
      end_frame(32'h00007FFF, 15);

      // Long frame, bit_cnt saturates at 17
      start_frame();
      shift_bits(32'h0001BCDE, 17);
      end_frame(32'h0001BCDE, 17);

      // Clear after 9 bits aborts silently
      v0 = n_valid;
      e0 = n_err;
      start_frame();
      shift_bits(32'h000001FF, 9);
      chk("bit_cnt_9", {27'd0, bit_cnt}, 32'd9);
      s_clr_n = 1'b0;
      step(4);
      s_clr_n = 1'b1;
      step(4);
      chk("clr_bit_cnt", {27'd0, bit_cnt}, 32'd0);
      chk("clr_busy", {31'd0, busy}, 32'd0);
      s_en = 1'b0;
      step(8);
      chk("clr_no_pulse", 32'((n_valid - v0) + (n_err - e0)), 32'd0);
      chk("clr_dout_held", {16'd0, dout}, {16'd0, exp_dout});
      start_frame();
      shift_bits(32'h00001234, 16);
      end_frame(32'h00001234, 16);

      // Reset mid-frame after 5 bits
      start_frame();
      shift_bits(32'h0000001F, 5);
      rst = 1'b0;
      #1;
      chk("mid_rst_dout", {16'd0, dout}, 32'd0);
      chk("mid_rst_cnt", {27'd0, bit_cnt}, 32'd0);
      s_en = 1'b0;
      step(3);
      chk("mid_rst_flags", {29'd0, dout_valid, frame_err, busy}, 32'd0);
      exp_dout = 16'h0000;
      rst = 1'b1;
      step(4);
      start_frame();
      shift_bits(32'h0000FFFF, 16);
      end_frame(32'h0000FFFF, 16);

      // Back-to-back frames with a 3 clk gap
      v0 = n_valid;
      start_frame();
      shift_bits(32'h00000001, 16);
      chk("b2b_cnt", {27'd0, bit_cnt}, 32'd16);
      s_en = 1'b0;
      step(3);
      s_en = 1'b1;
      step(1);
      chk("b2b_valid1", {31'd0, dout_valid}, 32'd1);
      chk("b2b_dout1", {16'd0, dout}, 32'h00000001);
      exp_dout = 16'h0001;
      step(3);
      shift_bits(32'h00008000, 16);
      end_frame(32'h00008000, 16);
      chk("b2b_pulses", 32'(n_valid - v0), 32'd2);

      // Randomized frames of 14..18 bits
      for (int k = 0; k < 8; k++) begin
         rw = $urandom;
         rn = $urandom_range(14, 18);
         start_frame();
         shift_bits(rw, rn);
         end_frame(rw, rn);
      end

      chk("never_both", 32'(n_both), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
